// File: rtl/kitchen_timer_ctrl.sv
// kitchen_timer_ctrl
//   MM:SS kitchen countdown timer controller, four-state FSM (idle / run / pause / alarm).
//   All outputs are registered.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   min_pb_i     one-cycle minute button pulse
//   sec_pb_i     one-cycle second button pulse
//   start_pb_i   one-cycle start/stop button pulse
//   clear_pb_i   one-cycle clear button pulse
//   tick_i       one-cycle 1 Hz pulse
//   min_tens_o   BCD minutes, tens digit
//   min_ones_o   BCD minutes, ones digit
//   sec_tens_o   BCD seconds, tens digit (0..5)
//   sec_ones_o   BCD seconds, ones digit
//   running_o    high while counting down
//   alarm_o      high while the alarm sounds
//   blank_o      display blanking flag, flashes in pause and alarm
module kitchen_timer_ctrl #(
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       min_pb_i,
    input  logic       sec_pb_i,
    input  logic       start_pb_i,
    input  logic       clear_pb_i,
    input  logic       tick_i,
    output logic [3:0] min_tens_o,
    output logic [3:0] min_ones_o,
    output logic [3:0] sec_tens_o,
    output logic [3:0] sec_ones_o,
    output logic       running_o,
    output logic       alarm_o,
    output logic       blank_o
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} state_e;

    // Counter value at which the next tick is the last one of the alarm.
    localparam logic [7:0] AlarmLast = 8'(ALARM_SECS - 1);

    state_e     state_q, state_d;
    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [3:0] mt_d, mo_d, st_d, so_d;
    logic [7:0] acnt_q, acnt_d;
    logic       running_q, running_d;
    logic       alarm_q, alarm_d;
    logic       blank_q, blank_d;

    logic do_clear, do_start, do_tick, do_min, do_sec;
    logic time_zero, time_last;
    logic blank_toggle;

    // Only the highest-priority pulse of a cycle is acted on; the rest are dropped.
    always_comb begin
        do_clear = clear_pb_i;
        do_start = !clear_pb_i && start_pb_i;
        do_tick  = !clear_pb_i && !start_pb_i && tick_i;
        do_min   = !clear_pb_i && !start_pb_i && !tick_i && min_pb_i;
        do_sec   = !clear_pb_i && !start_pb_i && !tick_i && !min_pb_i && sec_pb_i;
    end

    assign time_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    // 00:01 (or 00:00 as a safety net) means the next tick ends the countdown.
    assign time_last = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q <= 4'd1);

    always_comb begin
        state_d      = state_q;
        mt_d         = mt_q;
        mo_d         = mo_q;
        st_d         = st_q;
        so_d         = so_q;
        acnt_d       = acnt_q;
        blank_toggle = 1'b0;

        if (do_clear) begin
            state_d = StIdle;
            mt_d    = 4'd0;
            mo_d    = 4'd0;
            st_d    = 4'd0;
            so_d    = 4'd0;
            acnt_d  = 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (do_start) begin
                        if (!time_zero) state_d = StRun;
                    end else if (do_min) begin
                        // Minutes wrap 99 -> 00, seconds untouched.
                        if (mo_q == 4'd9) begin
                            mo_d = 4'd0;
                            mt_d = (mt_q == 4'd9) ? 4'd0 : mt_q + 4'd1;
                        end else begin
                            mo_d = mo_q + 4'd1;
                        end
                    end else if (do_sec) begin
                        // Seconds wrap 59 -> 00 with no carry into minutes.
                        if (so_q == 4'd9) begin
                            so_d = 4'd0;
                            st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
                        end else begin
                            so_d = so_q + 4'd1;
                        end
                    end
                end

                StRun: begin
                    if (do_start) begin
                        state_d = StPause;
                    end else if (do_tick) begin
                        if (time_last) begin
                            mt_d    = 4'd0;
                            mo_d    = 4'd0;
                            st_d    = 4'd0;
                            so_d    = 4'd0;
                            acnt_d  = 8'd0;
                            state_d = StAlarm;
                        end else if (so_q != 4'd0) begin
                            so_d = so_q - 4'd1;
                        end else begin
                            // BCD borrow chain through the remaining digits.
                            so_d = 4'd9;
                            if (st_q != 4'd0) begin
                                st_d = st_q - 4'd1;
                            end else begin
                                st_d = 4'd5;
                                if (mo_q != 4'd0) begin
                                    mo_d = mo_q - 4'd1;
                                end else begin
                                    mo_d = 4'd9;
                                    mt_d = mt_q - 4'd1;
                                end
                            end
                        end
                    end
                end

                StPause: begin
                    if (do_start) begin
                        state_d = StRun;
                    end else if (do_tick) begin
                        blank_toggle = 1'b1;
                    end
                end

                StAlarm: begin
                    if (do_start || do_min || do_sec) begin
                        state_d = StIdle;
                        acnt_d  = 8'd0;
                    end else if (do_tick) begin
                        if (acnt_q >= AlarmLast) begin
                            state_d = StIdle;
                            acnt_d  = 8'd0;
                        end else begin
                            acnt_d       = acnt_q + 8'd1;
                            blank_toggle = 1'b1;
                        end
                    end
                end

                default: state_d = StIdle;
            endcase
        end

        running_d = (state_d == StRun);
        alarm_d   = (state_d == StAlarm);
        // Flash phase restarts at 0 on every state change.
        if (state_d != state_q) begin
            blank_d = 1'b0;
        end else if (blank_toggle) begin
            blank_d = !blank_q;
        end else begin
            blank_d = blank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mt_q      <= 4'd0;
            mo_q      <= 4'd0;
            st_q      <= 4'd0;
            so_q      <= 4'd0;
            acnt_q    <= 8'd0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            blank_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mt_q      <= mt_d;
            mo_q      <= mo_d;
            st_q      <= st_d;
            so_q      <= so_d;
            acnt_q    <= acnt_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
            blank_q   <= blank_d;
        end
    end

    assign min_tens_o = mt_q;
    assign min_ones_o = mo_q;
    assign sec_tens_o = st_q;
    assign sec_ones_o = so_q;
    assign running_o  = running_q;
    assign alarm_o    = alarm_q;
    assign blank_o    = blank_q;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
module tb_kitchen_timer_ctrl;

    localparam int unsigned AlarmSecs = 3;

    // Input encodings {clear, start, tick, min, sec}
    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] SEC   = 5'b00001;
    localparam logic [4:0] MIN   = 5'b00010;
    localparam logic [4:0] TICK  = 5'b00100;
    localparam logic [4:0] START = 5'b01000;
    localparam logic [4:0] CLR   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       min_pb = 1'b0, sec_pb = 1'b0, start_pb = 1'b0, clear_pb = 1'b0, tick = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, alarm, blank;
    logic [18:0] dut_out;

    kitchen_timer_ctrl #(
        .ALARM_SECS(AlarmSecs)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .min_pb_i   (min_pb),
        .sec_pb_i   (sec_pb),
        .start_pb_i (start_pb),
        .clear_pb_i (clear_pb),
        .tick_i     (tick),
        .min_tens_o (min_tens),
        .min_ones_o (min_ones),
        .sec_tens_o (sec_tens),
        .sec_ones_o (sec_ones),
        .running_o  (running),
        .alarm_o    (alarm),
        .blank_o    (blank)
    );

    always #5 clk = ~clk;

    assign dut_out = {min_tens, min_ones, sec_tens, sec_ones, running, alarm, blank};

    typedef struct {
        logic [4:0]  in;
        logic [15:0] t;
        logic        r;
        logic        a;
        logic        b;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h (mmss=%h r=%b a=%b b=%b) expected=%h (mmss=%h r=%b a=%b b=%b)",
                     name, act, act[18:3], act[2], act[1], act[0],
                     exp, exp[18:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic [4:0] in, input logic [15:0] t,
                       input logic r, input logic a, input logic b);
        vec_t v;
        v.in = in; v.t = t; v.r = r; v.a = a; v.b = b;
        vecs.push_back(v);
    endtask

    // Drive one cycle of pulses, leave the DUT settled 1 time unit after the edge.
    task automatic step(input logic [4:0] in);
        @(negedge clk);
        {clear_pb, start_pb, tick, min_pb, sec_pb} = in;
        @(posedge clk);
        #1;
        {clear_pb, start_pb, tick, min_pb, sec_pb} = NONE;
    endtask

    task automatic repeat_step(input logic [4:0] in, input int n);
        for (int i = 0; i < n; i++) step(in);
    endtask

    initial begin
        // Main sequence, expected outputs after each edge.
        add(NONE,        16'h0000, 0, 0, 0);
        add(MIN,         16'h0100, 0, 0, 0);
        add(MIN,         16'h0200, 0, 0, 0);
        add(SEC,         16'h0201, 0, 0, 0);
        add(SEC,         16'h0202, 0, 0, 0);
        add(SEC,         16'h0203, 0, 0, 0);
        add(START,       16'h0203, 1, 0, 0);
        add(TICK,        16'h0202, 1, 0, 0);
        add(TICK,        16'h0201, 1, 0, 0);
        add(TICK,        16'h0200, 1, 0, 0);
        add(MIN,         16'h0200, 1, 0, 0);   // ignored in run
        add(TICK,        16'h0159, 1, 0, 0);   // borrow
        add(START|TICK,  16'h0159, 0, 0, 0);   // pause, tick dropped
        add(TICK,        16'h0159, 0, 0, 1);
        add(TICK,        16'h0159, 0, 0, 0);
        add(SEC,         16'h0159, 0, 0, 0);   // ignored in pause
        add(TICK,        16'h0159, 0, 0, 1);
        add(START,       16'h0159, 1, 0, 0);   // resume, blank forced 0
        add(CLR|TICK,    16'h0000, 0, 0, 0);
        add(START,       16'h0000, 0, 0, 0);   // start at 00:00 ignored
        add(SEC,         16'h0001, 0, 0, 0);
        add(SEC,         16'h0002, 0, 0, 0);
        add(START,       16'h0002, 1, 0, 0);
        add(TICK,        16'h0001, 1, 0, 0);
        add(TICK,        16'h0000, 0, 1, 0);   // alarm on same edge
        add(TICK,        16'h0000, 0, 1, 1);
        add(TICK,        16'h0000, 0, 1, 0);
        add(TICK,        16'h0000, 0, 0, 0);   // AlarmSecs-th tick -> idle
        add(MIN|SEC,     16'h0100, 0, 0, 0);   // min wins, sec dropped
        add(CLR,         16'h0000, 0, 0, 0);
        add(SEC,         16'h0001, 0, 0, 0);
        add(START,       16'h0001, 1, 0, 0);
        add(TICK,        16'h0000, 0, 1, 0);
        add(SEC,         16'h0000, 0, 0, 0);   // acknowledge
        add(START|MIN,   16'h0000, 0, 0, 0);   // start wins (ignored), min dropped
        add(MIN,         16'h0100, 0, 0, 0);
        add(START,       16'h0100, 1, 0, 0);
        add(TICK|MIN,    16'h0059, 1, 0, 0);
        add(CLR|START,   16'h0000, 0, 0, 0);

        // Reset state
        #1 rst_n = 1'b0;
        #2 check("reset_state", dut_out, 19'd0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].in);
            check($sformatf("vec%0d", i), dut_out, {vecs[i].t, vecs[i].r, vecs[i].a, vecs[i].b});
        end

        // Minute wrap 99 -> 00
        step(CLR);
        repeat_step(MIN, 99);
        check("min_99", dut_out, {16'h9900, 3'b000});
        step(MIN);
        check("min_wrap", dut_out, {16'h0000, 3'b000});

        // Second wrap 59 -> 00, minutes held
        repeat_step(MIN, 3);
        repeat_step(SEC, 59);
        check("sec_59", dut_out, {16'h0359, 3'b000});
        step(SEC);
        check("sec_wrap", dut_out, {16'h0300, 3'b000});

        // Full borrow 10:00 -> 09:59
        step(CLR);
        repeat_step(MIN, 10);
        step(START);
        step(TICK);
        check("borrow_1000", dut_out, {16'h0959, 3'b100});

        // Alarm acknowledged via start
        step(CLR);
        step(SEC);
        step(START);
        step(TICK);
        check("alarm_enter", dut_out, {16'h0000, 3'b010});
        step(TICK);
        check("alarm_blank", dut_out, {16'h0000, 3'b011});
        step(START);
        check("alarm_ack_start", dut_out, {16'h0000, 3'b000});

        // Asynchronous reset mid-run, no clock edge in between
        step(CLR);
        step(MIN);
        step(START);
        check("run_before_reset", dut_out, {16'h0100, 3'b100});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_run", dut_out, 19'd0);
        @(negedge clk) rst_n = 1'b1;
        step(NONE);
        check("after_reset", dut_out, 19'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
